// File: rtl/axis_fifo.sv
// axis_fifo: single-clock first-word-fall-through AXI4-Stream FIFO storing {tlast, tkeep, tdata} beats.
// Define AXIS_FIFO_COUNT_EN to add the occupancy output port `count`.
module axis_fifo #(
  parameter int TDATA_WIDTH = 4,
  parameter int TKEEP_WIDTH = 64,
  parameter int FIFO_DEPTH  = 64
) (
  input  logic                           s_axis_aclk,
  input  logic                           s_axis_aresetn,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic [TDATA_WIDTH*8-1:0]       s_axis_tdata,
  input  logic [TKEEP_WIDTH-1:0]         s_axis_tkeep,
  input  logic                           s_axis_tlast,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [TDATA_WIDTH*8-1:0]       m_axis_tdata,
  output logic [TKEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                           m_axis_tlast,
`ifdef AXIS_FIFO_COUNT_EN
  output logic [$clog2(FIFO_DEPTH):0]    count,
`endif
  output logic                           empty,
  output logic                           full
);

  localparam int DW = TDATA_WIDTH * 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = DW + TKEEP_WIDTH + 1;

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] wr_ptr_d;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] rd_ptr_d;
  logic          wr_en_s;
  logic          rd_en_s;
  logic          empty_s;
  logic          full_s;
  logic [EW-1:0] head_s;

  // Pointers carry one extra wrap bit so equal indices distinguish full from empty.
  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign s_axis_tready = s_axis_aresetn && !full_s;
  assign m_axis_tvalid = !empty_s;
  assign empty         = empty_s;
  assign full          = full_s;

  // Write enable omits reset: pointers are held at zero while reset is asserted anyway.
  assign wr_en_s = s_axis_tvalid && !full_s;
  assign rd_en_s = !empty_s && m_axis_tready;

  assign head_s = mem_q[rd_ptr_q[AW-1:0]];
  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = head_s;

`ifdef AXIS_FIFO_COUNT_EN
  assign count = wr_ptr_q - rd_ptr_q;
`endif

  // Next-state pointer arithmetic, modulo 2*FIFO_DEPTH through natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers; async reset discards all stored entries at once.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are deliberately not cleared by reset.
  always_ff @(posedge s_axis_aclk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    end
  end

endmodule

// File: tb/tb_axis_fifo.sv
// Self-checking bench for axis_fifo: queue-based scoreboard checked every negedge plus directed literal checks.
module tb_axis_fifo;

  localparam int DEPTH = 64;
  localparam int DW    = 32;
  localparam int KW    = 64;
  localparam int EW    = DW + KW + 1;

  logic          clk;
  logic          rst_n;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast;
  logic          empty;
  logic          full;
`ifdef AXIS_FIFO_COUNT_EN
  logic [6:0]    count;
`endif

  int tests = 0;
  int fails = 0;

  logic [EW-1:0] mq [$];
  logic [DW:0]   obs [$];
  bit            w_m;
  bit            r_m;

  axis_fifo #(.TDATA_WIDTH(4), .TKEEP_WIDTH(KW), .FIFO_DEPTH(DEPTH)) dut (
    .s_axis_aclk   (clk),
    .s_axis_aresetn(rst_n),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tlast  (s_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast),
`ifdef AXIS_FIFO_COUNT_EN
    .count         (count),
`endif
    .empty         (empty),
    .full          (full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a plain queue of accepted beats.
  always @(posedge clk) begin
    if (rst_n) begin
      w_m = s_tvalid && (mq.size() < DEPTH);
      r_m = m_tready && (mq.size() > 0);
      if (r_m) void'(mq.pop_front());
      if (w_m) mq.push_back({s_tlast, s_tkeep, s_tdata});
    end
  end

  always @(negedge rst_n) mq.delete();

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    chk("m_tvalid", m_tvalid, mq.size() != 0);
    chk("empty", empty, mq.size() == 0);
    chk("full", full, mq.size() == DEPTH);
    chk("s_tready", s_tready, rst_n && (mq.size() < DEPTH));
    if (mq.size() != 0) begin
      chk("m_tdata", m_tdata, mq[0][DW-1:0]);
      chk("m_tkeep", m_tkeep, mq[0][DW+KW-1:DW]);
      chk("m_tlast", m_tlast, mq[0][EW-1]);
    end
`ifdef AXIS_FIFO_COUNT_EN
    chk("count", count, mq.size());
`endif
    if (m_tvalid && m_tready && rst_n) obs.push_back({m_tlast, m_tdata});
  end

  task automatic put(input logic [DW-1:0] d);
    s_tvalid = 1'b1;
    s_tdata  = d;
    tick();
  endtask

  initial begin
    bit acc;
    int tries;
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = 32'd0;
    s_tkeep  = {KW{1'b1}};
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    tick();
    tick();
    chk("rst_tready", s_tready, 1'b0);
    chk("rst_tvalid", m_tvalid, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    rst_n = 1'b1;
    tick();

    // Pass-through order
    obs.delete();
    m_tready = 1'b1;
    for (int i = 0; i < 6; i++) put(32'(15 - i));
    s_tvalid = 1'b0;
    repeat (4) tick();
    chk("t1_cnt", obs.size(), 6);
    if (obs.size() == 6) for (int i = 0; i < 6; i++) chk("t1_data", obs[i][DW-1:0], 32'(15 - i));
    chk("t1_empty", empty, 1'b1);

    // Fill to full, reject overflow, drain
    obs.delete();
    m_tready = 1'b0;
    for (int i = 0; i < 64; i++) put(32'(i));
    s_tvalid = 1'b0;
    chk("t2_full", full, 1'b1);
    chk("t2_tready", s_tready, 1'b0);
    put(32'd99);
    put(32'd99);
    s_tvalid = 1'b0;
    chk("t2_full_hold", full, 1'b1);
    m_tready = 1'b1;
    repeat (70) tick();
    chk("t2_cnt", obs.size(), 64);
    if (obs.size() == 64) for (int i = 0; i < 64; i++) chk("t2_data", obs[i][DW-1:0], 32'(i));
    chk("t2_empty", empty, 1'b1);

    // Simultaneous read and write at occupancy 10
    obs.delete();
    m_tready = 1'b0;
    for (int i = 0; i < 10; i++) put(32'(200 + i));
    m_tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      put(32'(300 + i));
      chk("t3_full", full, 1'b0);
      chk("t3_empty", empty, 1'b0);
`ifdef AXIS_FIFO_COUNT_EN
      chk("t3_count", count, 7'd10);
`endif
    end
    s_tvalid = 1'b0;
    repeat (15) tick();
    chk("t3_cnt", obs.size(), 30);
    if (obs.size() == 30) begin
      for (int i = 0; i < 10; i++) chk("t3_data_a", obs[i][DW-1:0], 32'(200 + i));
      for (int i = 0; i < 20; i++) chk("t3_data_b", obs[10 + i][DW-1:0], 32'(300 + i));
    end

    // Wrap-around with tlast and random backpressure
    obs.delete();
    for (int i = 0; i < 200; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 32'(i);
      s_tkeep  = {~32'(i), 32'(i)};
      s_tlast  = (i % 8 == 7);
      tries    = 0;
      acc      = 1'b0;
      while (!acc && tries < 40) begin
        m_tready = 1'($urandom_range(0, 1));
        acc = (mq.size() < DEPTH);
        tries++;
        tick();
      end
      if (!acc) begin
        fails++;
        tests++;
        $display("FAIL t4_timeout: beat %0d not accepted within 40 cycles", i);
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tkeep  = {KW{1'b1}};
    m_tready = 1'b1;
    repeat (80) tick();
    chk("t4_cnt", obs.size(), 200);
    if (obs.size() == 200) for (int i = 0; i < 200; i++) begin
      chk("t4_data", obs[i][DW-1:0], 32'(i));
      chk("t4_tlast", obs[i][DW], (i % 8 == 7));
    end

    // Reset mid-operation
    obs.delete();
    m_tready = 1'b0;
    for (int i = 1; i <= 5; i++) put(32'(i));
    s_tvalid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_empty", empty, 1'b1);
    chk("t5_tvalid", m_tvalid, 1'b0);
    chk("t5_tready", s_tready, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("t5_tready_rel", s_tready, 1'b1);
    m_tready = 1'b1;
    put(32'd42);
    s_tvalid = 1'b0;
    repeat (3) tick();
    chk("t5_cnt", obs.size(), 1);
    if (obs.size() == 1) chk("t5_first", obs[0][DW-1:0], 32'd42);

    // Backpressure stability
    obs.delete();
    m_tready = 1'b0;
    put(32'd7);
    s_tvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_tvalid", m_tvalid, 1'b1);
      chk("t6_tdata", m_tdata, 32'd7);
    end
    m_tready = 1'b1;
    repeat (3) tick();
    chk("t6_cnt", obs.size(), 1);
    chk("t6_empty", empty, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_fifo.md
Name: axis_fifo

Overview:
Single-clock, synchronous AXI4-Stream FIFO that buffers tdata/tkeep/tlast beats between an upstream slave port and a downstream master port. It is first-word-fall-through: the head entry is always presented on the master port. It sits in the application datapath as an elastic buffer between stream producers and consumers. It also exposes full/empty status flags.

Parameters:
TDATA_WIDTH, 4, tdata width in bytes; the tdata bus is TDATA_WIDTH*8 bits.
TKEEP_WIDTH, 64, tkeep width in bits; independent of TDATA_WIDTH and stored verbatim.
FIFO_DEPTH, 64, number of entries; must be a power of two and at least 2.

Ports:
s_axis_aclk  in  1  sole clock; all logic is on its rising edge.
s_axis_aresetn  in  1  asynchronous active-low reset.
s_axis_tvalid  in  1  upstream beat valid.
s_axis_tready  out  1  FIFO can accept a beat.
s_axis_tdata  in  TDATA_WIDTH*8  upstream data.
s_axis_tkeep  in  TKEEP_WIDTH  upstream byte qualifiers.
s_axis_tlast  in  1  upstream end of packet.
m_axis_tvalid  out  1  head entry valid.
m_axis_tready  in  1  downstream accepts the beat.
m_axis_tdata  out  TDATA_WIDTH*8  head entry data.
m_axis_tkeep  out  TKEEP_WIDTH  head entry tkeep.
m_axis_tlast  out  1  head entry tlast.
empty  out  1  FIFO holds 0 entries.
full  out  1  FIFO holds FIFO_DEPTH entries.

Behaviour:
- Storage: FIFO_DEPTH x {tlast, tkeep, tdata} memory.
- Pointers: write and read pointers, each log2(FIFO_DEPTH)+1 bits wide; the MSB is the wrap bit.
- empty = (wr_ptr == rd_ptr).
- full = index bits equal and wrap bits differ.
- Reset (async assert, sync release): both pointers = 0, empty = 1, full = 0, s_axis_tready = 0, m_axis_tvalid = 0. m_axis_tdata/tkeep/tlast are don't-care while empty. Memory contents are not cleared.
- Reset asserted mid-operation discards all stored entries immediately.
- s_axis_tready = !full, and is forced to 0 while reset is asserted.
- Write: on a clock edge with s_axis_tvalid && s_axis_tready, store the beat at wr_ptr and increment wr_ptr.
- Read side (first-word-fall-through): m_axis_tvalid = !empty, and m_axis_tdata/tkeep/tlast = mem[rd_ptr] combinationally.
- Read: on a clock edge with m_axis_tvalid && m_axis_tready, increment rd_ptr.
- Latency: a beat written at edge N is visible on the master port with m_axis_tvalid = 1 immediately after edge N, i.e. 1 cycle.
- Throughput: one write and one read per cycle, sustained.
- Simultaneous read and write in the same cycle: both occur and occupancy is unchanged.
  - When full, the write is blocked in that cycle even if a read occurs (tready is low).
  - When empty, no read occurs and the write proceeds.
- Wrap-around: pointers increment modulo 2*FIFO_DEPTH. Ordering is strictly preserved.
- tvalid/tdata on the slave port are ignored whenever tready is 0. The master side holds its outputs stable while tvalid && !tready.

Optional Feature:
AXIS_FIFO_COUNT_EN
- Defined: adds output port count, width log2(FIFO_DEPTH)+1, equal to wr_ptr - rd_ptr.
  - Reset value 0.
  - Updates on the same edge as the pointers.
  - Range 0..FIFO_DEPTH.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Pass-through order: reset released, m_axis_tready=1, tkeep=all ones, tlast=0. Write 15,14,13,12,11,10 on consecutive cycles, then tvalid=0. Expected: m_axis_tdata shows 15..10 in order, each with tkeep all ones; then m_axis_tvalid=0 and empty=1.
- Fill to full: m_axis_tready=0, write 64 beats (values 0..63). Expected: full=1 and s_axis_tready=0 after the 64th beat; a 65th beat (value 99) is not accepted. Then set m_axis_tready=1. Expected: 0..63 drained in order, 99 never appears, empty=1 at the end.
- Simultaneous read and write: with 10 entries stored, drive tvalid=1 and tready=1 for 20 cycles. Expected: occupancy stays 10 and full/empty both stay 0; with AXIS_FIFO_COUNT_EN defined, count stays 10.
- Wrap-around with tlast: stream 200 beats (value i, tlast=1 every 8th beat) with random m_axis_tready. Expected: the output sequence equals the input and tlast is on beats 7, 15, 23, ...
- Reset mid-operation: with 5 entries stored, pulse s_axis_aresetn low between clock edges. Expected: empty=1, m_axis_tvalid=0 and s_axis_tready=0 immediately. After release, s_axis_tready=1, and the next write (value 42) is the first beat output.
- Backpressure stability: head=7, m_axis_tready=0 for 5 cycles. Expected: m_axis_tvalid=1 and m_axis_tdata=7 stable throughout.
